// File: rtl/rob_pkg.sv
// Shared widths, uop record, dispatch FSM states and the lane-count thermometer helper
// for the 4-way ROB insert path.
package rob_pkg;

  localparam int ROB_DEPTH = 128;
  localparam int ROB_IDX_W = $clog2(ROB_DEPTH);
  localparam int ARCH_W    = 5;
  localparam int PHYS_W    = 8;
  localparam int OPC_W     = 11;
  localparam int LANES     = 4;
  localparam int MAX_OCC   = 125;
  localparam int OCC_W     = 8;
  localparam int CNT_W     = 3;

  typedef logic [ROB_IDX_W-1:0] rob_idx_t;

  typedef struct packed {
    logic [ARCH_W-1:0] arch;
    logic [PHYS_W-1:0] phys;
    logic [OPC_W-1:0]  opcode;
  } rob_uop_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    RECOVER = 2'd2
  } dispatch_state_e;

  function automatic logic [LANES-1:0] thermometer(input logic [CNT_W-1:0] n);
    case (n)
      3'd0:    return 4'b0000;
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      3'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/rob_dispatch_lane_compactor.sv
// Combinational pack of the valid lanes into the low lanes (order preserved), with the
// popcount and matching thermometer mask. Zero latency, no flow control of its own.
module lane_compactor
  import rob_pkg::*;
(
  input  logic     [LANES-1:0] valid,
  input  rob_uop_t [LANES-1:0] uop_in,
  output rob_uop_t [LANES-1:0] uop_out,
  output logic     [CNT_W-1:0] cnt,
  output logic     [LANES-1:0] mask
);

  logic [CNT_W-1:0] pos;

  always_comb begin
    uop_out = '0;
    pos     = '0;
    for (int i = 0; i < LANES; i++) begin
      if (valid[i]) begin
        uop_out[pos[1:0]] = uop_in[i];
        pos               = pos + CNT_W'(1);
      end
    end
    cnt  = pos;
    mask = thermometer(pos);
  end

endmodule

// File: rtl/rob_dispatch.sv
// Producer side of the 4-way ROB insert: compacts renamed uops into one registered bundle
// (1-cycle latency), tracks tail/occupancy, and holds the bundle while the ROB cannot take it.
module rob_dispatch
  import rob_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  dec_valid,
  input  logic [19:0] dec_arch,
  input  logic [31:0] dec_phys,
  input  logic [43:0] dec_opcode,
  output logic        dec_ready,
  input  logic        rob_full,
  input  logic [2:0]  num_commited,
  input  logic        recover,
  input  logic [6:0]  recover_tail,
  input  logic [7:0]  recover_occ,
  output logic [3:0]  inserted,
  output logic [19:0] archReg,
  output logic [31:0] physReg,
  output logic [43:0] opcode,
  output logic [27:0] rob_idx,
  output logic [7:0]  occupancy
);

  rob_uop_t [LANES-1:0] dec_uop;
  rob_uop_t [LANES-1:0] pack_uop;
  rob_uop_t [LANES-1:0] held_uop;
  logic [CNT_W-1:0]     pack_cnt;
  logic [CNT_W-1:0]     cnt_held;
  logic [LANES-1:0]     pack_mask;
  logic [LANES-1:0]     mask_held;
  dispatch_state_e      state;
  rob_idx_t             tail;
  logic [OCC_W-1:0]     occ;
  logic [OCC_W-1:0]     occ_after;
  logic                 out_valid;
  logic                 fire;
  logic                 accept;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign dec_uop[k] = '{arch:   dec_arch[ARCH_W*k +: ARCH_W],
                          phys:   dec_phys[PHYS_W*k +: PHYS_W],
                          opcode: dec_opcode[OPC_W*k +: OPC_W]};
    assign archReg[ARCH_W*k +: ARCH_W]       = held_uop[k].arch;
    assign physReg[PHYS_W*k +: PHYS_W]       = held_uop[k].phys;
    assign opcode[OPC_W*k +: OPC_W]          = held_uop[k].opcode;
    assign rob_idx[ROB_IDX_W*k +: ROB_IDX_W] = tail + rob_idx_t'(k);
  end

  lane_compactor u_compactor (
    .valid   (dec_valid),
    .uop_in  (dec_uop),
    .uop_out (pack_uop),
    .cnt     (pack_cnt),
    .mask    (pack_mask)
  );

  // Occupancy the ROB would reach if the held bundle went in this cycle.
  assign occ_after = occ - OCC_W'(num_commited) + OCC_W'(cnt_held);

  assign fire = out_valid & ~rob_full & (occ_after <= OCC_W'(MAX_OCC))
              & (state != RECOVER) & ~recover & ~reset;

  assign dec_ready = (state == RUN) & (~out_valid | fire) & ~recover & ~reset;
  assign accept    = dec_ready & (|dec_valid);
  assign inserted  = fire ? mask_held : '0;
  assign occupancy = occ;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      tail      <= '0;
      occ       <= '0;
      out_valid <= 1'b0;
      cnt_held  <= '0;
      mask_held <= '0;
      held_uop  <= '0;
    end else if (recover) begin
      state     <= RECOVER;
      tail      <= recover_tail;
      occ       <= recover_occ;
      out_valid <= 1'b0;
    end else begin
      occ <= occ + (fire ? OCC_W'(cnt_held) : '0) - OCC_W'(num_commited);
      if (fire) tail <= tail + rob_idx_t'(cnt_held);

      if (accept) begin
        out_valid <= 1'b1;
        held_uop  <= pack_uop;
        cnt_held  <= pack_cnt;
        mask_held <= pack_mask;
      end else if (fire) begin
        out_valid <= 1'b0;
      end

      case (state)
        RUN:     if (out_valid && !fire) state <= STALL;
        STALL:   if (fire) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // The ROB can only retire what is resident, and inserts never push past the full threshold.
  a_commit_le_occ: assert property (@(posedge clk) disable iff (reset || recover)
                                    OCC_W'(num_commited) <= occ);
  a_occ_le_max:    assert property (@(posedge clk) disable iff (reset)
                                    occ <= OCC_W'(MAX_OCC));

endmodule

// File: tb/tb_rob_dispatch.sv
// Directed table, hand-written corner sequences and a randomized run against a bundle-level
// model of the ROB insert producer.
`timescale 1ns/1ps
module tb_rob_dispatch;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  dec_valid;
  logic [19:0] dec_arch;
  logic [31:0] dec_phys;
  logic [43:0] dec_opcode;
  logic        dec_ready;
  logic        rob_full;
  logic [2:0]  num_commited;
  logic        recover;
  logic [6:0]  recover_tail;
  logic [7:0]  recover_occ;
  logic [3:0]  inserted;
  logic [19:0] archReg;
  logic [31:0] physReg;
  logic [43:0] opcode;
  logic [27:0] rob_idx;
  logic [7:0]  occupancy;

  int total = 0;
  int bad   = 0;

  localparam logic [19:0] ARCH_A = {5'd4, 5'd3, 5'd2, 5'd1};
  localparam logic [19:0] ARCH_B = {5'd9, 5'd0, 5'd7, 5'd0};

  always #5 clk = ~clk;

  rob_dispatch dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_arch(dec_arch),
    .dec_phys(dec_phys), .dec_opcode(dec_opcode), .dec_ready(dec_ready),
    .rob_full(rob_full), .num_commited(num_commited), .recover(recover),
    .recover_tail(recover_tail), .recover_occ(recover_occ), .inserted(inserted),
    .archReg(archReg), .physReg(physReg), .opcode(opcode), .rob_idx(rob_idx),
    .occupancy(occupancy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [27:0] idx4(input int t);
    logic [27:0] r;
    for (int k = 0; k < 4; k++) r[7*k +: 7] = 7'((t + k) % 128);
    return r;
  endfunction

  task automatic drive(input logic rst, input logic [3:0] v, input logic [19:0] a,
                       input logic full, input logic [2:0] nc, input logic rec,
                       input logic [6:0] rt, input logic [7:0] ro);
    reset = rst; dec_valid = v; dec_arch = a; rob_full = full;
    num_commited = nc; recover = rec; recover_tail = rt; recover_occ = ro;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [19:0] arch;
    logic        full;
    logic [2:0]  nc;
    logic        rec;
    logic [6:0]  rt;
    logic [7:0]  ro;
    logic [3:0]  e_ins;
    logic        e_rdy;
    logic [27:0] e_idx;
    logic [7:0]  e_occ;
    logic [4:0]  e_a0;
    logic [4:0]  e_a1;
  } vec_t;

  vec_t vt[14];

  // bundle-level reference model state
  int          m_tail, m_occ, m_cnt;
  bit          m_hv, m_wait, m_rec;
  logic [4:0]  m_arch[4];
  logic [7:0]  m_phys[4];
  logic [10:0] m_opc[4];

  initial begin
    dec_phys   = 32'h44332211;
    dec_opcode = 44'h0;
    drive(1'b1, 4'b0, 20'd0, 1'b0, 3'd0, 1'b0, 7'd0, 8'd0);
    step(); step();
    @(negedge clk);
    chk("rst_ins",  32'(inserted), 32'd0);
    chk("rst_rdy",  32'(dec_ready), 32'd0);
    chk("rst_occ",  32'(occupancy), 32'd0);
    chk("rst_idx",  32'(rob_idx), 32'(idx4(0)));
    chk("rst_arch", 32'(archReg), 32'd0);
    step();

    //          v        arch    full  nc    rec   rt      ro     ins      rdy   idx         occ     a0    a1
    vt[0]  = '{4'b1111, ARCH_A, 1'b0, 3'd0, 1'b0, 7'd0,   8'd0, 4'b0000, 1'b1, idx4(0),   8'd0,  5'd0, 5'd0};
    vt[1]  = '{4'b1111, ARCH_A, 1'b0, 3'd0, 1'b0, 7'd0,   8'd0, 4'b1111, 1'b1, idx4(0),   8'd0,  5'd1, 5'd2};
    vt[2]  = '{4'b1111, ARCH_A, 1'b0, 3'd0, 1'b0, 7'd0,   8'd0, 4'b1111, 1'b1, idx4(4),   8'd4,  5'd1, 5'd2};
    vt[3]  = '{4'b0000, ARCH_A, 1'b0, 3'd0, 1'b0, 7'd0,   8'd0, 4'b1111, 1'b1, idx4(8),   8'd8,  5'd1, 5'd2};
    vt[4]  = '{4'b0000, ARCH_A, 1'b0, 3'd3, 1'b0, 7'd0,   8'd0, 4'b0000, 1'b1, idx4(12),  8'd12, 5'd0, 5'd0};
    vt[5]  = '{4'b1111, ARCH_A, 1'b0, 3'd0, 1'b1, 7'd10,  8'd0, 4'b0000, 1'b0, idx4(12),  8'd9,  5'd0, 5'd0};
    vt[6]  = '{4'b1010, ARCH_B, 1'b0, 3'd0, 1'b0, 7'd0,   8'd0, 4'b0000, 1'b0, idx4(10),  8'd0,  5'd0, 5'd0};
    vt[7]  = '{4'b1010, ARCH_B, 1'b0, 3'd0, 1'b0, 7'd0,   8'd0, 4'b0000, 1'b1, idx4(10),  8'd0,  5'd0, 5'd0};
    vt[8]  = '{4'b0000, ARCH_B, 1'b0, 3'd0, 1'b0, 7'd0,   8'd0, 4'b0011, 1'b1, idx4(10),  8'd0,  5'd7, 5'd9};
    vt[9]  = '{4'b0000, ARCH_B, 1'b0, 3'd0, 1'b1, 7'd126, 8'd2, 4'b0000, 1'b0, idx4(12),  8'd2,  5'd0, 5'd0};
    vt[10] = '{4'b1111, ARCH_A, 1'b0, 3'd0, 1'b0, 7'd0,   8'd0, 4'b0000, 1'b0, idx4(126), 8'd2,  5'd0, 5'd0};
    vt[11] = '{4'b1111, ARCH_A, 1'b0, 3'd0, 1'b0, 7'd0,   8'd0, 4'b0000, 1'b1, idx4(126), 8'd2,  5'd0, 5'd0};
    vt[12] = '{4'b0000, ARCH_A, 1'b0, 3'd0, 1'b0, 7'd0,   8'd0, 4'b1111, 1'b1, idx4(126), 8'd2,  5'd1, 5'd2};
    vt[13] = '{4'b0000, ARCH_A, 1'b0, 3'd0, 1'b0, 7'd0,   8'd0, 4'b0000, 1'b1, idx4(2),   8'd6,  5'd0, 5'd0};

    for (int r = 0; r < 14; r++) begin
      drive(1'b0, vt[r].v, vt[r].arch, vt[r].full, vt[r].nc, vt[r].rec, vt[r].rt, vt[r].ro);
      @(negedge clk);
      chk($sformatf("tbl%0d_ins", r), 32'(inserted),  32'(vt[r].e_ins));
      chk($sformatf("tbl%0d_rdy", r), 32'(dec_ready), 32'(vt[r].e_rdy));
      chk($sformatf("tbl%0d_idx", r), 32'(rob_idx),   32'(vt[r].e_idx));
      chk($sformatf("tbl%0d_occ", r), 32'(occupancy), 32'(vt[r].e_occ));
      if (vt[r].e_ins[0]) chk($sformatf("tbl%0d_a0", r), 32'(archReg[4:0]), 32'(vt[r].e_a0));
      if (vt[r].e_ins[1]) chk($sformatf("tbl%0d_a1", r), 32'(archReg[9:5]), 32'(vt[r].e_a1));
      step();
    end

    // occupancy stall: 123 + 4 exceeds the limit until two entries retire
    drive(1'b0, 4'b0000, ARCH_A, 1'b0, 3'd0, 1'b1, 7'd20, 8'd123);
    @(negedge clk); chk("occ_rec_ins", 32'(inserted), 32'd0); step();
    drive(1'b0, 4'b1111, ARCH_A, 1'b0, 3'd0, 1'b0, 7'd0, 8'd0);
    @(negedge clk); chk("occ_rcv_rdy", 32'(dec_ready), 32'd0); chk("occ_rcv_occ", 32'(occupancy), 32'd123); step();
    @(negedge clk); chk("occ_acc_rdy", 32'(dec_ready), 32'd1); step();
    drive(1'b0, 4'b1111, ARCH_B, 1'b0, 3'd0, 1'b0, 7'd0, 8'd0);
    @(negedge clk); chk("occ_st_ins", 32'(inserted), 32'd0); chk("occ_st_rdy", 32'(dec_ready), 32'd0); step();
    @(negedge clk); chk("occ_st2_ins", 32'(inserted), 32'd0); chk("occ_st2_rdy", 32'(dec_ready), 32'd0);
    chk("occ_st2_arch", 32'(archReg), 32'(ARCH_A)); step();
    drive(1'b0, 4'b1111, ARCH_B, 1'b0, 3'd2, 1'b0, 7'd0, 8'd0);
    @(negedge clk); chk("occ_fire_ins", 32'(inserted), 32'hF); chk("occ_fire_rdy", 32'(dec_ready), 32'd0);
    chk("occ_fire_idx", 32'(rob_idx), 32'(idx4(20))); step();
    drive(1'b0, 4'b0011, ARCH_B, 1'b0, 3'd0, 1'b0, 7'd0, 8'd0);
    @(negedge clk); chk("occ_after", 32'(occupancy), 32'd125); chk("occ_after_ins", 32'(inserted), 32'd0);
    chk("occ_after_rdy", 32'(dec_ready), 32'd1); chk("occ_after_idx", 32'(rob_idx), 32'(idx4(24))); step();

    // stalled bundle dropped by recover
    drive(1'b0, 4'b0000, ARCH_A, 1'b0, 3'd0, 1'b0, 7'd0, 8'd0);
    @(negedge clk); chk("rcv_st_ins", 32'(inserted), 32'd0); chk("rcv_st_rdy", 32'(dec_ready), 32'd0); step();
    drive(1'b0, 4'b0000, ARCH_A, 1'b0, 3'd0, 1'b1, 7'd40, 8'd3);
    @(negedge clk); chk("rcv_p_ins", 32'(inserted), 32'd0); chk("rcv_p_rdy", 32'(dec_ready), 32'd0); step();
    drive(1'b0, 4'b1111, ARCH_A, 1'b0, 3'd0, 1'b0, 7'd0, 8'd0);
    @(negedge clk); chk("rcv_s_ins", 32'(inserted), 32'd0); chk("rcv_s_rdy", 32'(dec_ready), 32'd0);
    chk("rcv_s_occ", 32'(occupancy), 32'd3); chk("rcv_s_idx", 32'(rob_idx), 32'(idx4(40))); step();
    drive(1'b0, 4'b0111, ARCH_A, 1'b0, 3'd0, 1'b0, 7'd0, 8'd0);
    @(negedge clk); chk("rcv_drop_ins", 32'(inserted), 32'd0); chk("rcv_acc_rdy", 32'(dec_ready), 32'd1); step();
    drive(1'b0, 4'b0000, ARCH_A, 1'b0, 3'd0, 1'b0, 7'd0, 8'd0);
    @(negedge clk); chk("rcv_new_ins", 32'(inserted), 32'h7); chk("rcv_new_idx", 32'(rob_idx), 32'(idx4(40)));
    chk("rcv_new_arch", 32'(archReg[14:0]), 32'({5'd3, 5'd2, 5'd1})); step();
    @(negedge clk); chk("rcv_new_occ", 32'(occupancy), 32'd6); step();

    // reset while a bundle is stalled behind rob_full
    drive(1'b0, 4'b1111, ARCH_B, 1'b0, 3'd0, 1'b0, 7'd0, 8'd0);
    @(negedge clk); chk("rs_acc_rdy", 32'(dec_ready), 32'd1); step();
    drive(1'b0, 4'b1111, ARCH_A, 1'b1, 3'd0, 1'b0, 7'd0, 8'd0);
    @(negedge clk); chk("rs_full_ins", 32'(inserted), 32'd0); chk("rs_full_rdy", 32'(dec_ready), 32'd0); step();
    drive(1'b1, 4'b1111, ARCH_A, 1'b0, 3'd0, 1'b0, 7'd0, 8'd0);
    @(negedge clk); chk("rs_in_ins", 32'(inserted), 32'd0); chk("rs_in_rdy", 32'(dec_ready), 32'd0); step();
    drive(1'b0, 4'b0000, ARCH_A, 1'b0, 3'd0, 1'b0, 7'd0, 8'd0);
    @(negedge clk); chk("rs_out_ins", 32'(inserted), 32'd0); chk("rs_out_rdy", 32'(dec_ready), 32'd1);
    chk("rs_out_occ", 32'(occupancy), 32'd0); chk("rs_out_idx", 32'(rob_idx), 32'(idx4(0))); step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("rs_quiet_ins", 32'(inserted), 32'd0); step();
    end

    // randomized run against the bundle-level model
    drive(1'b1, 4'b0, 20'd0, 1'b0, 3'd0, 1'b0, 7'd0, 8'd0);
    step();
    m_tail = 0; m_occ = 0; m_cnt = 0; m_hv = 0; m_wait = 0; m_rec = 0;
    for (int c = 0; c < 3000; c++) begin
      logic       rst, rec, full, fire, e_rdy;
      logic [3:0] v, e_ins;
      logic [19:0] a;
      logic [2:0] nc;
      int         nci;
      rst  = ($urandom_range(0, 199) == 0);
      rec  = ($urandom_range(0, 29) == 0);
      full = ($urandom_range(0, 3) == 0);
      v    = 4'($urandom);
      a    = 20'($urandom);
      nc   = 3'($urandom_range(0, (m_occ < 4) ? m_occ : 4));
      nci  = int'(nc);
      dec_phys   = $urandom;
      dec_opcode = 44'({$urandom, $urandom});
      drive(rst, v, a, full, nc, rec, 7'($urandom), 8'($urandom_range(0, 125)));

      fire  = m_hv && !full && (m_occ - nci + m_cnt <= 125) && !m_rec && !rec && !rst;
      e_ins = fire ? 4'((1 << m_cnt) - 1) : 4'd0;
      e_rdy = !rst && !rec && !m_rec && (!m_hv || (fire && !m_wait));

      @(negedge clk);
      chk("rnd_ins", 32'(inserted),  32'(e_ins));
      chk("rnd_rdy", 32'(dec_ready), 32'(e_rdy));
      chk("rnd_occ", 32'(occupancy), 32'(m_occ));
      if (fire) begin
        for (int k = 0; k < m_cnt; k++)
          chk("rnd_lane", {1'b0, archReg[5*k +: 5], physReg[8*k +: 8], opcode[11*k +: 11], rob_idx[7*k +: 7]},
                          {1'b0, m_arch[k], m_phys[k], m_opc[k], 7'((m_tail + k) % 128)});
      end

      if (rst) begin
        m_tail = 0; m_occ = 0; m_hv = 0; m_wait = 0; m_rec = 0; m_cnt = 0;
      end else if (rec) begin
        m_tail = int'(recover_tail); m_occ = int'(recover_occ);
        m_hv = 0; m_wait = 0; m_rec = 1;
      end else begin
        m_occ = m_occ + (fire ? m_cnt : 0) - nci;
        if (fire) m_tail = (m_tail + m_cnt) % 128;
        if (e_rdy && v != 4'd0) begin
          m_cnt = 0;
          for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
              m_arch[m_cnt] = a[5*i +: 5];
              m_phys[m_cnt] = dec_phys[8*i +: 8];
              m_opc[m_cnt]  = dec_opcode[11*i +: 11];
              m_cnt++;
            end
          end
          m_hv = 1; m_wait = 0;
        end else if (fire) begin
          m_hv = 0; m_wait = 0;
        end else if (m_hv) begin
          m_wait = 1;
        end
        m_rec = 0;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
